perceptron_feeder: RTL and testbench

Stream source that buffers training/inference samples and drives them into the perceptron datapath over the valid/ready handshake. Software or a testbench loads up to DEPTH samples through a simple write port, pulses `start`, and the feeder emits them in order, optionally over several epochs. It honours downstream backpressure so it can drive the perceptron pipeline's input side directly: `val_o` drives `val_i`, and `rdy_i` is driven by `rdy_o`.

---
 rtl/perceptron_feeder_if.sv | 36 +++
 rtl/perceptron_feeder.sv | 160 ++++++++++++++++
 tb/tb_perceptron_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_feeder_if.sv
// perceptron_feeder_if
// Purpose: valid/ready stream bundle that carries one sample per transfer.
// A feeder drives it from the master side and the perceptron datapath
// consumes it from the slave side.
// Signals:
//   val_o   - data_o holds a valid sample
//   rdy_i   - consumer can accept the sample this cycle
//   data_o  - packed sample (features plus label), DATA_W bits
//   last_o  - data_o is the last sample of its epoch
//   epoch_o - 0-based epoch index of data_o, EPOCH_W bits
interface perceptron_feeder_if #(
    parameter int DATA_W  = 16,
    parameter int EPOCH_W = 8
);
    logic               val_o;
    logic               rdy_i;
    logic [DATA_W-1:0]  data_o;
    logic               last_o;
    logic [EPOCH_W-1:0] epoch_o;

    modport master (
        output val_o,
        output data_o,
        output last_o,
        output epoch_o,
        input  rdy_i
    );

    modport slave (
        input  val_o,
        input  data_o,
        input  last_o,
        input  epoch_o,
        output rdy_i
    );
endinterface

// File: rtl/perceptron_feeder.sv
// perceptron_feeder
// Purpose: buffers up to DEPTH samples written through a simple write port,
// then on start streams them in order over a valid/ready handshake,
// optionally repeating the whole buffer for several epochs.
// Optional feature macro: FEEDER_MULTI_EPOCH_EN
//   defined   - num_epochs sets the number of passes over the buffer
//   undefined - exactly one pass; num_epochs is ignored, epoch_o is 0
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-low reset
//   clear            - empty the buffer (only while idle)
//   wr_en, wr_data   - append a sample (only while idle, dropped when full)
//   wr_full          - buffer holds DEPTH samples
//   start            - begin streaming (only while idle, buffer not empty)
//   num_epochs       - passes over the buffer, sampled at start
//   busy             - streaming in progress
//   done             - one-cycle pulse after the final transfer
//   strm             - master side of the sample stream
module perceptron_feeder #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_full,
    input  logic               start,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               busy,
    output logic               done,
    perceptron_feeder_if.master strm
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [EPOCH_W-1:0] ep_q, ep_d;
    logic [EPOCH_W-1:0] ep_max_q, ep_max_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               last_q, last_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we;

    logic [CNT_W-1:0]   last_idx;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [EPOCH_W-1:0] ep_limit;

`ifdef FEEDER_MULTI_EPOCH_EN
    // num_epochs == 0 is treated like 1: there is always at least one pass
    assign ep_limit = (num_epochs == '0) ? '0 : num_epochs - EPOCH_W'(1);
`else
    assign ep_limit = '0;
`endif

    assign last_idx   = count_q - CNT_W'(1);
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        ep_d     = ep_q;
        ep_max_d = ep_max_q;
        data_d   = data_q;
        last_d   = last_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (wr_en && !wr_full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
                // A simultaneous clear empties the buffer, so start must not
                // launch a stream of samples that no longer exist.
                if (start && (count_q != '0) && !clear) begin
                    state_d  = STREAM;
                    rd_ptr_d = '0;
                    ep_d     = '0;
                    ep_max_d = ep_limit;
                    data_d   = mem_q[0];
                    last_d   = (count_d == CNT_W'(1));
                end
            end
            STREAM: begin
                if (strm.rdy_i) begin
                    if ({1'b0, rd_ptr_q} == last_idx) begin
                        if (ep_q < ep_max_q) begin
                            // Wrap to the next epoch without a bubble
                            rd_ptr_d = '0;
                            ep_d     = ep_q + EPOCH_W'(1);
                            data_d   = mem_q[0];
                            last_d   = (count_q == CNT_W'(1));
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_nxt;
                        data_d   = mem_q[rd_ptr_nxt];
                        last_d   = ({1'b0, rd_ptr_nxt} == last_idx);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            ep_q     <= '0;
            ep_max_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ep_q     <= ep_d;
            ep_max_q <= ep_max_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    // Sample storage has no reset; count_q alone defines which entries are live
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[count_q[PTR_W-1:0]] <= wr_data;
        end
    end

    assign wr_full     = (count_q == CNT_W'(DEPTH));
    assign busy        = (state_q == STREAM);
    assign done        = (state_q == DONE);
    assign strm.val_o  = (state_q == STREAM);
    assign strm.data_o = data_q;
    assign strm.last_o = last_q;
`ifdef FEEDER_MULTI_EPOCH_EN
    assign strm.epoch_o = ep_q;
`else
    assign strm.epoch_o = '0;
`endif
endmodule

// File: tb/tb_perceptron_feeder.sv
// tb_perceptron_feeder
// Purpose: directed self-checking bench for perceptron_feeder. Loads samples,
// streams them with and without backpressure, and checks buffer overflow,
// multi-epoch replay, empty-buffer starts, clear priority and reset abort.
// Expected streams are built by the bench from the samples it wrote.
module tb_perceptron_feeder;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int EPOCH_W = 8;

    logic               clk;
    logic               reset;
    logic               clear;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_full;
    logic               start;
    logic [EPOCH_W-1:0] num_epochs;
    logic               busy;
    logic               done;

    perceptron_feeder_if #(.DATA_W(DATA_W), .EPOCH_W(EPOCH_W)) sif ();

    perceptron_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .EPOCH_W(EPOCH_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .start     (start),
        .num_epochs(num_epochs),
        .busy      (busy),
        .done      (done),
        .strm      (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]  got_d[$];
    logic               got_l[$];
    logic [EPOCH_W-1:0] got_e[$];
    logic [DATA_W-1:0]  exp_d[$];
    logic               exp_l[$];
    logic [EPOCH_W-1:0] exp_e[$];
    bit                 rdy_seq[$];
    int                 done_cyc;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic apply_stimulus_start(input logic [EPOCH_W-1:0] n);
        num_epochs = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic apply_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Drive rdy_i from rdy_seq (then 1) and record transfers until done
    task automatic drain(input int budget);
        int                cyc = 0;
        bit                seen = 0;
        bit                holding = 0;
        logic [DATA_W-1:0] held = '0;
        got_d.delete();
        got_l.delete();
        got_e.delete();
        done_cyc = -1;
        while (!seen && cyc < budget) begin
            sif.rdy_i = (rdy_seq.size() > 0) ? rdy_seq.pop_front() : 1'b1;
            if (holding) begin
                check_output("hold_val", 32'(sif.val_o), 32'd1);
                check_output("hold_data", 32'(sif.data_o), 32'(held));
            end
            holding = 0;
            if (done) begin
                seen     = 1;
                done_cyc = cyc;
            end
            if (sif.val_o && sif.rdy_i) begin
                got_d.push_back(sif.data_o);
                got_l.push_back(sif.last_o);
                got_e.push_back(sif.epoch_o);
            end else if (sif.val_o) begin
                holding = 1;
                held    = sif.data_o;
            end
            tick();
            cyc++;
        end
        sif.rdy_i = 1'b1;
        check_output("done_seen", 32'(seen), 32'd1);
        check_output("done_pulse_len", 32'(done), 32'd0);
        check_output("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic compare_stream(input string name);
        int n;
        check_output({name, "_xfer_count"}, 32'(got_d.size()), 32'(exp_d.size()));
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_data%0d", name, i), 32'(got_d[i]), 32'(exp_d[i]));
            check_output($sformatf("%s_last%0d", name, i), 32'(got_l[i]), 32'(exp_l[i]));
            check_output($sformatf("%s_epoch%0d", name, i), 32'(got_e[i]), 32'(exp_e[i]));
        end
    endtask

    task automatic expect_pass(input logic [DATA_W-1:0] base, input int n, input int step, input int ep);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(base + DATA_W'(i * step));
            exp_l.push_back(i == n - 1);
            exp_e.push_back(EPOCH_W'(ep));
        end
    endtask

    task automatic clear_expect();
        exp_d.delete();
        exp_l.delete();
        exp_e.delete();
    endtask

    initial begin
        reset      = 1'b0;
        clear      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        start      = 1'b0;
        num_epochs = '0;
        sif.rdy_i  = 1'b1;

        // Reset state
        tick();
        tick();
        check_output("rst_val", 32'(sif.val_o), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_full", 32'(wr_full), 32'd0);
        check_output("rst_data", 32'(sif.data_o), 32'd0);
        check_output("rst_last", 32'(sif.last_o), 32'd0);
        check_output("rst_epoch", 32'(sif.epoch_o), 32'd0);
        reset = 1'b1;
        tick();

        // Three samples, no backpressure
        write_sample(16'h0011);
        write_sample(16'h0022);
        write_sample(16'h0033);
        apply_stimulus_start(8'd1);
        check_output("start_val", 32'(sif.val_o), 32'd1);
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_data", 32'(sif.data_o), 32'h0011);
        drain(20);
        clear_expect();
        expect_pass(16'h0011, 3, 16'h0011, 0);
        compare_stream("basic");
        check_output("basic_done_cycle", 32'(done_cyc), 32'd3);

        // Replay of the retained buffer with stalls
        rdy_seq = '{1, 0, 0, 1, 0, 1};
        apply_stimulus_start(8'd1);
        drain(30);
        compare_stream("stall");
        check_output("stall_done_cycle", 32'(done_cyc), 32'd6);

        // Overflow: DEPTH+2 writes, the last two dropped
        apply_clear();
        check_output("clear_full", 32'(wr_full), 32'd0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_sample(16'h0100 + 16'(i));
            if (i == DEPTH - 2) check_output("not_full_yet", 32'(wr_full), 32'd0);
            if (i == DEPTH - 1) check_output("full_at_depth", 32'(wr_full), 32'd1);
        end
        check_output("full_after_extra", 32'(wr_full), 32'd1);
        apply_stimulus_start(8'd1);
        drain(100);
        clear_expect();
        expect_pass(16'h0100, DEPTH, 1, 0);
        compare_stream("full");
        check_output("full_done_cycle", 32'(done_cyc), 32'(DEPTH));

        // Multi-epoch request
        apply_clear();
        write_sample(16'h0011);
        write_sample(16'h0022);
        apply_stimulus_start(8'd3);
        drain(40);
        clear_expect();
`ifdef FEEDER_MULTI_EPOCH_EN
        for (int e = 0; e < 3; e++) expect_pass(16'h0011, 2, 16'h0011, e);
        compare_stream("epochs");
        check_output("epochs_done_cycle", 32'(done_cyc), 32'd6);
`else
        expect_pass(16'h0011, 2, 16'h0011, 0);
        compare_stream("epochs");
        check_output("epochs_done_cycle", 32'(done_cyc), 32'd2);
`endif

        // Empty buffer start, then clear beating a simultaneous write
        apply_clear();
        apply_stimulus_start(8'd1);
        check_output("empty_start_val", 32'(sif.val_o), 32'd0);
        check_output("empty_start_busy", 32'(busy), 32'd0);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h0055;
        tick();
        clear   = 1'b0;
        wr_en   = 1'b0;
        check_output("clr_wr_full", 32'(wr_full), 32'd0);
        apply_stimulus_start(8'd1);
        check_output("clr_wr_start_val", 32'(sif.val_o), 32'd0);
        tick();
        check_output("clr_wr_idle_val", 32'(sif.val_o), 32'd0);
        // Buffer must be truly empty: the next write lands at entry 0 alone
        write_sample(16'h0066);
        sif.rdy_i = 1'b0;
        apply_stimulus_start(8'd1);
        check_output("single_val", 32'(sif.val_o), 32'd1);
        check_output("single_data", 32'(sif.data_o), 32'h0066);
        check_output("single_last", 32'(sif.last_o), 32'd1);
        drain(10);

        // Reset mid-stream after one of four transfers
        apply_clear();
        for (int i = 0; i < 4; i++) write_sample(16'h0A00 + 16'(i));
        apply_stimulus_start(8'd1);
        sif.rdy_i = 1'b1;
        tick();
        check_output("rst_mid_data1", 32'(sif.data_o), 32'h0A01);
        reset = 1'b0;
        tick();
        check_output("rst_mid_val", 32'(sif.val_o), 32'd0);
        check_output("rst_mid_busy", 32'(busy), 32'd0);
        check_output("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();
        check_output("rst_mid_no_done", 32'(done), 32'd0);
        apply_stimulus_start(8'd1);
        check_output("rst_start_ignored", 32'(sif.val_o), 32'd0);
        write_sample(16'h0077);
        apply_stimulus_start(8'd1);
        check_output("rst_new_val", 32'(sif.val_o), 32'd1);
        check_output("rst_new_data", 32'(sif.data_o), 32'h0077);
        check_output("rst_new_last", 32'(sif.last_o), 32'd1);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
